// File: rtl/lisnoc_router_arbiter_prio_age_pkg.sv
// rtl/lisnoc_router_arbiter_prio_age_pkg.sv - shared flit types, arbiter state and header field helpers
package lisnoc_router_arbiter_prio_age_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Data bit holding the priority-enable flag; the level bits sit directly below it.
    function automatic int prio_en_bit(input int data_width, input int prio_offset);
        return data_width - prio_offset - 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lisnoc_arb_prio_rr.sv
// rtl/lisnoc_arb_prio_rr.sv - round robin pick of the first requester cyclically after the last grant
module lisnoc_arb_prio_rr #(
    parameter int N = 5
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] gnt_i,
    output logic [N-1:0] nxt_gnt_o
);

    int   last_idx;
    logic found;

    always_comb begin
        nxt_gnt_o = '0;
        last_idx  = N - 1;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_i[i]) last_idx = i;
        end
        // Ports above the last grant come first, then wrap to the low ports.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i > last_idx)) begin
                nxt_gnt_o[i] = 1'b1;
                found        = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i <= last_idx)) begin
                nxt_gnt_o[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_router_arbiter_prio_age.sv
// rtl/lisnoc_router_arbiter_prio_age.sv - output-port arbiter with header priority, aging and wormhole lock
module lisnoc_router_arbiter_prio_age
    import lisnoc_router_arbiter_prio_age_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ph_prio_width   = 4,
    parameter int ph_prio_offset  = 5,
    parameter int ports           = 5,
    parameter int age_width       = 3,
    parameter int prio_en         = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [(flit_data_width+flit_type_width)*ports-1:0] flit_i,
    input  logic [ports-1:0]                                  request_i,
    input  logic                                              ready_i,
    output logic [flit_data_width+flit_type_width-1:0]        flit_o,
    output logic [ports-1:0]                                  read_o,
    output logic                                              valid_o,
    output logic                                              locked_o
);

    localparam int FlitWidth = flit_data_width + flit_type_width;
    localparam int LvlWidth  = ph_prio_width - 1;
    localparam int EffWidth  = max2(LvlWidth, age_width) + 1;
    localparam int PrioMsb   = prio_en_bit(flit_data_width, ph_prio_offset);
    localparam logic [age_width-1:0] AgeMax     = '1;
    localparam logic [ports-1:0]     LastGntRst = {1'b1, {(ports-1){1'b0}}};

    arb_state_t                         state_q, state_d;
    logic [ports-1:0]                   lock_sel_q, lock_sel_d;
    logic [ports-1:0]                   last_gnt_q, last_gnt_d;
    logic [ports-1:0][age_width-1:0]    age_q, age_d;
    logic [ports-1:0][EffWidth-1:0]     eff;
    logic [EffWidth-1:0]                max_eff;
    logic [ports-1:0]                   max_mask;
    logic [ports-1:0]                   rr_gnt;
    logic [ports-1:0]                   sel;
    logic [FlitWidth-1:0]               sel_flit;
    logic [flit_type_width-1:0]         sel_type;
    logic                               transfer;
    logic                               arb_event;

    for (genvar p = 0; p < ports; p++) begin : g_port
        logic [LvlWidth-1:0] lvl;

        assign lvl = flit_i[p*FlitWidth + PrioMsb] ?
                     flit_i[p*FlitWidth + PrioMsb - 1 -: LvlWidth] : '0;
        assign eff[p] = EffWidth'(lvl) + EffWidth'(age_q[p]);

        // Pure round robin puts every requester into the tie-break set.
        assign max_mask[p] = request_i[p] && ((prio_en == 0) || (eff[p] == max_eff));

        assign age_d[p] = !arb_event         ? age_q[p] :
                          sel[p]             ? '0 :
                          !request_i[p]      ? '0 :
                          (age_q[p] == AgeMax) ? AgeMax : age_q[p] + age_width'(1);
    end

    always_comb begin
        max_eff = '0;
        for (int p = 0; p < ports; p++) begin
            if (request_i[p] && (eff[p] > max_eff)) max_eff = eff[p];
        end
    end

    lisnoc_arb_prio_rr #(
        .N(ports)
    ) u_rr (
        .req_i     (max_mask),
        .gnt_i     (last_gnt_q),
        .nxt_gnt_o (rr_gnt)
    );

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        last_gnt_d = last_gnt_q;
        arb_event  = 1'b0;

        sel      = (state_q == ST_LOCKED) ? lock_sel_q : rr_gnt;
        valid_o  = !rst && (|(request_i & sel));
        transfer = valid_o && ready_i;
        read_o   = transfer ? sel : '0;

        sel_flit = '0;
        for (int p = 0; p < ports; p++) begin
            sel_flit = sel_flit | (flit_i[p*FlitWidth +: FlitWidth] & {FlitWidth{sel[p]}});
        end
        sel_type = sel_flit[FlitWidth-1 -: flit_type_width];

        case (state_q)
            ST_IDLE: begin
                if (transfer && ((sel_type == FLIT_TYPE_HEADER) || (sel_type == FLIT_TYPE_SINGLE))) begin
                    arb_event  = 1'b1;
                    last_gnt_d = sel;
                    if (sel_type == FLIT_TYPE_HEADER) begin
                        state_d    = ST_LOCKED;
                        lock_sel_d = sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (transfer && (sel_type == FLIT_TYPE_LAST)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign flit_o   = sel_flit;
    assign locked_o = (state_q == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            last_gnt_q <= LastGntRst;
            age_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            last_gnt_q <= last_gnt_d;
            age_q      <= age_d;
        end
    end

endmodule

// File: tb/tb_lisnoc_router_arbiter_prio_age.sv
// tb/tb_lisnoc_router_arbiter_prio_age.sv - scoreboard bench for the priority/age output arbiter
module tb_lisnoc_router_arbiter_prio_age;

    localparam int FW = 34;
    localparam int NP = 5;
    localparam logic [1:0] PAY = 2'b00;
    localparam logic [1:0] HDR = 2'b01;
    localparam logic [1:0] LST = 2'b10;
    localparam logic [1:0] SGL = 2'b11;

    typedef struct packed {
        logic [NP-1:0] oh;
        logic [FW-1:0] flit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [FW*NP-1:0] flit0, flit1;
    logic [NP-1:0]    req0, req1, read0, read1;
    logic             ready0, ready1, valid0, valid1, locked0, locked1;
    logic [FW-1:0]    fo0, fo1;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lisnoc_router_arbiter_prio_age #(.prio_en(1)) dut0 (
        .clk(clk), .rst(rst), .flit_i(flit0), .request_i(req0), .ready_i(ready0),
        .flit_o(fo0), .read_o(read0), .valid_o(valid0), .locked_o(locked0)
    );

    lisnoc_router_arbiter_prio_age #(.prio_en(0)) dut1 (
        .clk(clk), .rst(rst), .flit_i(flit1), .request_i(req1), .ready_i(ready1),
        .flit_o(fo1), .read_o(read1), .valid_o(valid1), .locked_o(locked1)
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [3:0] prio, input logic [7:0] tag);
        logic [FW-1:0] f;
        f        = '0;
        f[33:32] = t;
        f[26:23] = prio;
        f[7:0]   = tag;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive0(input int p, input logic [FW-1:0] f);
        req0[p]          = 1'b1;
        flit0[p*FW +: FW] = f;
    endtask

    task automatic off0(input int p);
        req0[p] = 1'b0;
    endtask

    task automatic expect0(input int p);
        exp_t e;
        e.oh   = NP'(1) << p;
        e.flit = flit0[p*FW +: FW];
        sb0.push_back(e);
    endtask

    task automatic expect1(input int p);
        exp_t e;
        e.oh   = NP'(1) << p;
        e.flit = flit1[p*FW +: FW];
        sb1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && valid0 && ready0) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_transfer read_o=%b flit_o=%h", read0, fo0);
            end else begin
                e = sb0.pop_front();
                if (read0 !== e.oh || fo0 !== e.flit) begin
                    failures++;
                    $display("FAIL dut0_grant read_o=%b flit_o=%h required read_o=%b flit_o=%h",
                             read0, fo0, e.oh, e.flit);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && valid1 && ready1) begin
            checks++;
            if (sb1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_transfer read_o=%b flit_o=%h", read1, fo1);
            end else begin
                e = sb1.pop_front();
                if (read1 !== e.oh || fo1 !== e.flit) begin
                    failures++;
                    $display("FAIL dut1_grant read_o=%b flit_o=%h required read_o=%b flit_o=%h",
                             read1, fo1, e.oh, e.flit);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        req0   = '1;
        req1   = '1;
        flit0  = '0;
        flit1  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_read", 32'(read0), 32'd0);
        check("rst_locked", 32'(locked0), 32'd0);
        check("rst_valid_rr", 32'(valid1), 32'd0);
        req0 = '0;
        req1 = '0;
        rst  = 1'b0;
        step();

        // Prio disabled in the header: tie resolved from last_gnt = 4.
        drive0(0, mk(SGL, 4'b0000, 8'h10));
        drive0(2, mk(SGL, 4'b0000, 8'h12));
        expect0(0);
        step();
        off0(0);
        expect0(2);
        step();
        off0(2);

        // Level 3 beats level 1, then port 3 waits for the whole packet.
        drive0(1, mk(HDR, 4'b1011, 8'h21));
        drive0(3, mk(HDR, 4'b1001, 8'h23));
        expect0(1);
        step();
        check("lock_after_header", 32'(locked0), 32'd1);
        drive0(1, mk(PAY, 4'b0000, 8'h22));
        expect0(1);
        step();
        ready0 = 1'b0;
        #1;
        check("not_ready_valid", 32'(valid0), 32'd1);
        check("not_ready_read", 32'(read0), 32'd0);
        step();
        ready0 = 1'b1;
        drive0(1, mk(PAY, 4'b0000, 8'h24));
        expect0(1);
        step();
        drive0(1, mk(LST, 4'b0000, 8'h25));
        expect0(1);
        step();
        check("unlock_after_last", 32'(locked0), 32'd0);
        off0(1);
        expect0(3);
        step();
        check("lock_port3", 32'(locked0), 32'd1);
        drive0(3, mk(LST, 4'b0000, 8'h26));
        expect0(3);
        step();
        off0(3);

        // Starvation: one lvl-7 port at a time vs port 4 at lvl 0; age must saturate at 7.
        for (int e = 0; e < 9; e++) begin
            drive0(e % 4, mk(SGL, 4'b1111, 8'(8'h30 + e)));
            drive0(4, mk(SGL, 4'b0000, 8'h40));
            expect0((e == 8) ? 4 : (e % 4));
            step();
            off0(e % 4);
        end
        off0(4);

        // Locked port 2 drops its request; ports 1 and 3 must not sneak in.
        drive0(1, mk(SGL, 4'b0000, 8'h51));
        drive0(3, mk(SGL, 4'b0000, 8'h53));
        drive0(2, mk(HDR, 4'b1111, 8'h52));
        expect0(2);
        step();
        drive0(2, mk(PAY, 4'b0000, 8'h54));
        expect0(2);
        step();
        off0(2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid", 32'(valid0), 32'd0);
            check("stall_read", 32'(read0), 32'd0);
            check("stall_locked", 32'(locked0), 32'd1);
            step();
        end
        drive0(2, mk(LST, 4'b0000, 8'h55));
        expect0(2);
        step();
        off0(2);
        expect0(3);
        step();
        off0(3);
        expect0(1);
        step();
        off0(1);

        // Reset in the middle of a packet, with port 3 carrying age.
        drive0(0, mk(HDR, 4'b1111, 8'h60));
        drive0(3, mk(SGL, 4'b0000, 8'h63));
        expect0(0);
        step();
        drive0(0, mk(PAY, 4'b0000, 8'h61));
        expect0(0);
        step();
        drive0(0, mk(PAY, 4'b0000, 8'h62));
        rst = 1'b1;
        #1;
        check("midrst_locked", 32'(locked0), 32'd0);
        check("midrst_valid", 32'(valid0), 32'd0);
        check("midrst_read", 32'(read0), 32'd0);
        step();
        rst = 1'b0;
        drive0(0, mk(SGL, 4'b0000, 8'h64));
        expect0(0);
        step();
        off0(0);
        expect0(3);
        step();
        off0(3);

        // Pure round robin ignores the differing header priorities.
        for (int p = 0; p < NP; p++) begin
            flit1[p*FW +: FW] = mk(SGL, {1'b1, 3'(p + 2)}, 8'(8'h70 + p));
        end
        req1 = '1;
        for (int i = 0; i < 6; i++) begin
            expect1(i % NP);
            step();
        end
        req1 = '0;
        step();

        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lisnoc_router_arbiter_prio_age.md
# lisnoc_router_arbiter_prio_age

Output-port arbiter for the LISNoC router that selects one of `ports` input arbiters per packet. It adds to plain priority arbitration a configurable priority field, a per-port saturating age counter for starvation freedom, a pure round-robin mode, and wormhole locking from header to last flit. It sits between the per-input arbiters and the output FIFO of one output port and virtual channel. It is a drop-in successor with the same flit/request/read/valid handshake.

## Interface
- `flit_data_width`, 32, flit payload bits
- `flit_type_width`, 2, flit type bits (MSBs of flit)
- `ph_prio_width`, 4, header priority field width; MSB = prio-enable, rest = level
- `ph_prio_offset`, 5, field occupies data bits `[flit_data_width-ph_prio_offset-1 -: ph_prio_width]`
- `ports`, 5, number of requesting inputs (≥2)
- `age_width`, 3, age counter width per port
- `prio_en`, 1, 1 = priority+age mode, 0 = pure round robin (level and age ignored)
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high (one clock domain, `clk`)
- `flit_i`  in  `(flit_data_width+flit_type_width)*ports`  flits, port p at slice p
- `request_i`  in  `ports`  port p requests this output
- `ready_i`  in  1  output FIFO can accept
- `flit_o`  out  `flit_data_width+flit_type_width`  flit of selected port
- `read_o`  out  `ports`  one-hot pop to selected input
- `valid_o`  out  1  flit_o valid, write to FIFO
- `locked_o`  out  1  packet in progress (registered)

## Operation
- Flit types are from `lisnoc_def.vh`: PAYLOAD=2'b00, HEADER=2'b01, LAST=2'b10, SINGLE=2'b11.
- Transfer: a cycle with `valid_o & ready_i`. `read_o` is one-hot on the selected port only when a transfer occurs, otherwise zero.
- State: IDLE (unlocked) and LOCKED(port). A HEADER transfer in IDLE goes to LOCKED(selected). A LAST transfer in LOCKED goes to IDLE. A SINGLE transfer stays in IDLE.
- In LOCKED(p), the selection is fixed to p. `valid_o = request_i[p]`. There is no arbitration and no age update. A dropped request stalls the packet (valid_o=0) and keeps the lock.
- In IDLE, the candidates are the ports with `request_i` set.
  - Effective priority eff[p] = lvl[p] + age[p], computed at width max(ph_prio_width-1, age_width)+1. There is no overflow.
  - lvl[p] is the level bits if the enable MSB is set, else 0.
  - The max mask holds the candidates with the maximal eff.
  - With `prio_en=0`, all candidates are in the max mask.
- Tie-break: round robin over the max mask. The first port cyclically after `last_gnt` wins.
- Arbitration event: an IDLE transfer (HEADER or SINGLE). On it:
  - `last_gnt` is set to the winner.
  - age[winner] is cleared to 0.
  - Every other requesting port increments age, saturating at 2^age_width-1.
  - Non-requesting ports are cleared to 0.
- No event means no change to age or `last_gnt`.
- `flit_o` = flit of the selected port in every cycle, including when invalid.
- Starvation bound (prio_en=1): a continuously requesting port wins within (2^(ph_prio_width-1)-1 + 2^age_width)·ports events.

## Timing
- Combinational path request_i/flit_i/ready_i → read_o/valid_o/flit_o. Grant is in the same cycle, zero latency, as in the existing arbiter.
- Registered: lock state, locked port, `last_gnt`, age[ ], `locked_o`.
- Reset (async, any cycle, including mid-packet):
  - lock cleared, `locked_o`=0
  - `last_gnt`=ports-1, so port 0 wins the first tie
  - all ages = 0
  - `read_o`=0 and `valid_o`=0 while `rst` is high
- Simultaneous events:
  - HEADER and LAST in the same flit are impossible by encoding.
  - A SINGLE transfer never locks.
  - A LAST transfer with new requests pending re-arbitrates in the next cycle. There is no bubble beyond that cycle.
- `ready_i`=0: no transfer, `read_o`=0, `valid_o` still reflects the request, state holds.

## Structure
- Flit type constants stay in `lisnoc_def.vh`/`lisnoc_undef.vh`. Add a shared define for the priority enable bit position only.
- Sub-module: reuse `lisnoc_arb_prio_rr` (N=ports) for the tie-break, with req = max mask and gnt = `last_gnt`.
- Max-mask and age logic are generate loops within this module.

## Test plan
- Reset, then SINGLE requests on ports 0 and 2 with prio disabled and ready=1 → port 0 is granted (read_o=5'b00001), then port 2 next cycle (5'b00100).
- Port 1 HEADER with prio=4'b1011 and port 3 HEADER with prio=4'b1001 → port 1 is granted, locked_o=1 next cycle. Port 3 is ignored through 2 PAYLOAD flits until LAST, then port 3 is granted.
- Port 4 continuously requests with prio 4'b0000, and ports 0–3 requeue SINGLEs with prio 4'b1111 (lvl=7), age_width=3 → port 4 is granted within the stated starvation bound. Its age saturates at 7 and never wraps to 0.
- prio_en=0 with all 5 ports requesting SINGLEs at differing prios → grants follow the order 0,1,2,3,4,0.
- Locked port 2 drops its request for 3 cycles mid-packet → valid_o=0 and read_o=0 for those 3 cycles. No other port is granted. Resume completes the packet.
- rst asserted mid-packet while locked → locked_o=0 immediately, valid_o=0, ages 0. After release, port 0 wins the first tie.
